// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode map, branch codes, FSM states and EX control bundle for the
// registered pipeline control unit.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_ATYPE = 4'b1111;

  localparam logic [1:0] BR_EQ = 2'b01;
  localparam logic [1:0] BR_GT = 2'b10;
  localparam logic [1:0] BR_LT = 2'b11;

  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned MUX_A_W  = 2;
  localparam int unsigned MUX_B_W  = 2;
  localparam int unsigned REG_WR_W = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALT   = 2'd2,
    ST_EXCEPT = 2'd3
  } state_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [MUX_A_W-1:0]  mux_a;
    logic [MUX_B_W-1:0]  mux_b;
    logic                mux_c;
    logic [REG_WR_W-1:0] reg_write;
    logic                byte_en;
    logic                mem_write;
    logic                r0_select;
  } ex_bundle_t;

  localparam ex_bundle_t BUNDLE_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_seq_decode.sv
// Combinational opcode decoder: EX control bundle, instruction class flags
// and illegal-opcode detection.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  logic [OPC_W-1:0] i_opcode,
  output ex_bundle_t       o_bundle,
  output logic             o_is_halt,
  output logic             o_is_jmp,
  output logic             o_is_branch,
  output logic [1:0]       o_br_cond,
  output logic             o_is_load,
  output logic             o_illegal
);

  logic w_hi;

  assign w_hi = (i_opcode >> 4) != '0;

  always_comb begin
    o_bundle    = BUNDLE_BUBBLE;
    o_is_halt   = 1'b0;
    o_is_jmp    = 1'b0;
    o_is_branch = 1'b0;
    o_br_cond   = '0;
    o_is_load   = 1'b0;
    o_illegal   = 1'b0;
    if (w_hi) begin
      o_illegal = 1'b1;
    end else begin
      case (i_opcode[3:0])
        OP_ATYPE: o_bundle = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0};
        OP_ANDI:  o_bundle = '{2'b00, 2'b00, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0};
        OP_ORI:   o_bundle = '{2'b10, 2'b00, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0};
        OP_LBU: begin
          o_bundle  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
          o_is_load = 1'b1;
        end
        OP_SB:    o_bundle = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        OP_LW: begin
          o_bundle  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
          o_is_load = 1'b1;
        end
        OP_SW:    o_bundle = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        OP_BGT: begin
          o_is_branch = 1'b1;
          o_br_cond   = BR_GT;
        end
        OP_BLT: begin
          o_is_branch = 1'b1;
          o_br_cond   = BR_LT;
        end
        OP_BEQ: begin
          o_is_branch = 1'b1;
          o_br_cond   = BR_EQ;
        end
        OP_JMP:   o_is_jmp  = 1'b1;
        OP_HALT:  o_is_halt = 1'b1;
        default:  o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Registered pipeline control: decodes the ID opcode into a one-cycle-late EX
// bundle and sequences stalls, branch/jump flushes, sticky halt and exceptions.
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W        = 4,
  parameter int unsigned REG_AW       = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPC_W-1:0]     opcode,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_src1,
  input  logic [REG_AW-1:0]    id_src2,
  input  logic [REG_AW-1:0]    ex_dst,
  input  logic [1:0]           branch_result,
  input  logic                 overflow_flag,
  input  logic                 err_ack,
  output logic                 pc_op,
  output logic                 b_jmp,
  output logic                 pc_hold,
  output logic                 if_flush,
  output logic                 id_flush,
  output logic                 ex_flush,
  output logic                 halt,
  output logic                 overflow_error_warning,
  output logic                 illegal_op,
  output logic [1:0]           alu_op,
  output logic [1:0]           mux_a,
  output logic [1:0]           mux_b,
  output logic [1:0]           reg_write,
  output logic                 mux_c,
  output logic                 byte_en,
  output logic                 mem_write,
  output logic                 r0_select,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_flush_cnt, w_flush_cnt_nxt;
  ex_bundle_t           r_bundle, w_bundle_nxt;
  logic                 r_ex_load, w_ex_load_nxt;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 w_err_inc;

  ex_bundle_t w_dec_bundle;
  logic       w_is_halt, w_is_jmp, w_is_branch, w_is_load, w_illegal;
  logic [1:0] w_br_cond;
  logic       w_taken, w_hazard;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .i_opcode    (opcode),
    .o_bundle    (w_dec_bundle),
    .o_is_halt   (w_is_halt),
    .o_is_jmp    (w_is_jmp),
    .o_is_branch (w_is_branch),
    .o_br_cond   (w_br_cond),
    .o_is_load   (w_is_load),
    .o_illegal   (w_illegal)
  );

  assign w_taken  = w_is_jmp | (w_is_branch & (branch_result == w_br_cond));
  assign w_hazard = r_ex_load & id_valid & ((ex_dst == id_src1) | (ex_dst == id_src2));

  always_comb begin
    w_state_nxt            = r_state;
    w_flush_cnt_nxt        = r_flush_cnt;
    w_bundle_nxt           = BUNDLE_BUBBLE;
    w_ex_load_nxt          = 1'b0;
    w_err_inc              = 1'b0;
    pc_op                  = 1'b0;
    b_jmp                  = 1'b0;
    pc_hold                = 1'b0;
    if_flush               = 1'b0;
    id_flush               = 1'b0;
    ex_flush               = 1'b0;
    halt                   = 1'b0;
    overflow_error_warning = 1'b0;
    illegal_op             = 1'b0;
    // Outputs are forced low while reset is held, not just after the first edge.
    if (reset) begin
      if (r_state != ST_HALT && overflow_flag) begin
        ex_flush               = 1'b1;
        id_flush               = 1'b1;
        if_flush               = 1'b1;
        halt                   = 1'b1;
        overflow_error_warning = 1'b1;
        w_err_inc              = 1'b1;
        w_flush_cnt_nxt        = '0;
        w_state_nxt            = ST_EXCEPT;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (id_valid && w_is_halt) begin
              halt        = 1'b1;
              if_flush    = 1'b1;
              w_state_nxt = ST_HALT;
            end else if (id_valid && w_taken) begin
              pc_op                  = 1'b1;
              b_jmp                  = w_is_branch;
              if_flush               = 1'b1;
              id_flush               = 1'b1;
              w_bundle_nxt.r0_select = w_is_branch;
              if (FLUSH_CYCLES > 1) begin
                w_state_nxt     = ST_FLUSH;
                w_flush_cnt_nxt = FLUSH_LOAD;
              end
            end else if (w_hazard) begin
              pc_hold = 1'b1;
            end else if (id_valid && w_illegal) begin
              illegal_op = 1'b1;
            end else if (id_valid) begin
              w_bundle_nxt  = w_dec_bundle;
              w_ex_load_nxt = w_is_load;
            end
          end
          ST_FLUSH: begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            if (r_flush_cnt <= 3'd1) begin
              w_flush_cnt_nxt = '0;
              w_state_nxt     = ST_RUN;
            end else begin
              w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            end
          end
          ST_HALT: begin
            halt     = 1'b1;
            if_flush = 1'b1;
          end
          ST_EXCEPT: begin
            ex_flush               = 1'b1;
            id_flush               = 1'b1;
            if_flush               = 1'b1;
            halt                   = 1'b1;
            overflow_error_warning = 1'b1;
            if (err_ack) w_state_nxt = ST_RUN;
          end
          default: w_state_nxt = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_bundle    <= BUNDLE_BUBBLE;
      r_ex_load   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_bundle    <= w_bundle_nxt;
      r_ex_load   <= w_ex_load_nxt;
      if (w_err_inc && r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign alu_op    = r_bundle.alu_op;
  assign mux_a     = r_bundle.mux_a;
  assign mux_b     = r_bundle.mux_b;
  assign mux_c     = r_bundle.mux_c;
  assign reg_write = r_bundle.reg_write;
  assign byte_en   = r_bundle.byte_en;
  assign mem_write = r_bundle.mem_write;
  assign r0_select = r_bundle.r0_select;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Directed bench for pipe_ctrl_seq (OPC_W=6, FLUSH_CYCLES=3, ERR_CNT_W=8).
module tb_pipe_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       id_valid;
  logic [3:0] id_src1, id_src2, ex_dst;
  logic [1:0] branch_result;
  logic       overflow_flag, err_ack;
  logic       pc_op, b_jmp, pc_hold, if_flush, id_flush, ex_flush;
  logic       halt, overflow_error_warning, illegal_op;
  logic [1:0] alu_op, mux_a, mux_b, reg_write;
  logic       mux_c, byte_en, mem_write, r0_select;
  logic [7:0] err_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // {alu_op, mux_a, mux_b, mux_c, reg_write, byte_en, mem_write, r0_select}
  localparam logic [11:0] B_ZERO  = 12'b00_00_00_0_00_0_0_0;
  localparam logic [11:0] B_ATYPE = 12'b01_00_00_1_11_0_0_0;
  localparam logic [11:0] B_ANDI  = 12'b00_00_11_1_11_0_0_0;
  localparam logic [11:0] B_ORI   = 12'b10_00_11_1_11_0_0_0;
  localparam logic [11:0] B_LBU   = 12'b11_11_00_0_11_1_0_0;
  localparam logic [11:0] B_SB    = 12'b11_11_00_0_00_1_1_0;
  localparam logic [11:0] B_LW    = 12'b11_11_00_0_11_0_0_0;
  localparam logic [11:0] B_SW    = 12'b11_11_00_0_00_0_1_0;
  localparam logic [11:0] B_BR    = 12'b00_00_00_0_00_0_0_1;

  logic [11:0] bun;
  logic [8:0]  flags;
  assign bun   = {alu_op, mux_a, mux_b, mux_c, reg_write, byte_en, mem_write, r0_select};
  // {pc_op, b_jmp, pc_hold, if_flush, id_flush, ex_flush, halt, warn, illegal}
  assign flags = {pc_op, b_jmp, pc_hold, if_flush, id_flush, ex_flush,
                  halt, overflow_error_warning, illegal_op};

  pipe_ctrl_seq #(
    .OPC_W(6), .REG_AW(4), .FLUSH_CYCLES(3), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .ex_dst(ex_dst),
    .branch_result(branch_result), .overflow_flag(overflow_flag), .err_ack(err_ack),
    .pc_op(pc_op), .b_jmp(b_jmp), .pc_hold(pc_hold), .if_flush(if_flush),
    .id_flush(id_flush), .ex_flush(ex_flush), .halt(halt),
    .overflow_error_warning(overflow_error_warning), .illegal_op(illegal_op),
    .alu_op(alu_op), .mux_a(mux_a), .mux_b(mux_b), .reg_write(reg_write),
    .mux_c(mux_c), .byte_en(byte_en), .mem_write(mem_write), .r0_select(r0_select),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic put(input logic [5:0] op, input logic v);
    opcode   = op;
    id_valid = v;
  endtask

  initial begin
    reset = 1'b0; opcode = '0; id_valid = 1'b0; id_src1 = 4'd1; id_src2 = 4'd2;
    ex_dst = 4'd7; branch_result = 2'b00; overflow_flag = 1'b0; err_ack = 1'b0;
    #3;
    check_eq("rst_flags", 32'(flags), 32'h0);
    check_eq("rst_bundle", 32'(bun), 32'(B_ZERO));
    check_eq("rst_errcnt", 32'(err_count), 32'h0);
    @(negedge clk); reset = 1'b1;

    // lw then ori: bundles appear one cycle after their opcode
    tick(); put(6'b001100, 1'b1); ex_dst = 4'd0;
    tick(); put(6'b000010, 1'b1); settle();
    check_eq("lw_bundle", 32'(bun), 32'(B_LW));
    check_eq("no_false_stall", 32'(pc_hold), 32'h0);
    tick(); check_eq("ori_bundle", 32'(bun), 32'(B_ORI));

    // load-use: lw in EX writes r3, add in ID reads r3
    put(6'b001100, 1'b1);
    tick(); put(6'b001111, 1'b1); id_src2 = 4'd3; ex_dst = 4'd3; settle();
    check_eq("stall_hold", 32'(pc_hold), 32'h1);
    tick(); check_eq("stall_bubble", 32'(bun), 32'(B_ZERO));
    check_eq("stall_clears", 32'(pc_hold), 32'h0);
    tick(); check_eq("add_issues", 32'(bun), 32'(B_ATYPE));
    id_src2 = 4'd2; ex_dst = 4'd7;

    // taken beq with FLUSH_CYCLES=3
    put(6'b000110, 1'b1); branch_result = 2'b01; settle();
    check_eq("beq_taken", 32'(flags), 32'b1_1_0_1_1_0_0_0_0);
    tick(); put(6'b001111, 1'b1); settle();
    check_eq("flush1_bundle", 32'(bun), 32'(B_BR));
    check_eq("flush1_flags", 32'(flags), 32'b0_0_0_1_1_0_0_0_0);
    tick(); check_eq("flush2_bundle", 32'(bun), 32'(B_ZERO));
    check_eq("flush2_flags", 32'(flags), 32'b0_0_0_1_1_0_0_0_0);
    tick(); check_eq("flush_done", 32'(flags), 32'h0);
    tick(); check_eq("post_flush_issue", 32'(bun), 32'(B_ATYPE));

    // same beq, comparator says gt: not taken
    put(6'b000110, 1'b1); branch_result = 2'b10; settle();
    check_eq("beq_not_taken", 32'(flags), 32'h0);
    tick(); check_eq("beq_nt_bundle", 32'(bun), 32'(B_ZERO));

    // blt taken, then jmp
    put(6'b000101, 1'b1); branch_result = 2'b11; settle();
    check_eq("blt_taken", 32'(flags), 32'b1_1_0_1_1_0_0_0_0);
    tick(); put(6'b000000, 1'b0); tick(); tick();
    put(6'b000111, 1'b1); settle();
    check_eq("jmp_flags", 32'(flags), 32'b1_0_0_1_1_0_0_0_0);
    tick(); put(6'b000000, 1'b0); settle();
    check_eq("jmp_bundle", 32'(bun), 32'(B_ZERO));
    tick(); tick(); settle();
    check_eq("jmp_back_run", 32'(flags), 32'h0);

    // overflow exception and acknowledge
    overflow_flag = 1'b1; settle();
    check_eq("ovf_flags", 32'(flags), 32'b0_0_0_1_1_1_1_1_0);
    tick(); check_eq("ovf_cnt1", 32'(err_count), 32'd1);
    err_ack = 1'b1;
    tick(); check_eq("ovf_ack_cnt2", 32'(err_count), 32'd2);
    overflow_flag = 1'b0; err_ack = 1'b0; settle();
    check_eq("except_held", 32'(flags), 32'b0_0_0_1_1_1_1_1_0);
    tick(); err_ack = 1'b1; settle();
    check_eq("except_ack_cycle", 32'(flags), 32'b0_0_0_1_1_1_1_1_0);
    tick(); err_ack = 1'b0; settle();
    check_eq("ack_to_run", 32'(flags), 32'h0);
    check_eq("ack_cnt_kept", 32'(err_count), 32'd2);

    // illegal opcode (upper bit set), then andi/lbu/sb/sw
    put(6'b010001, 1'b1); settle();
    check_eq("illegal_pulse", 32'(illegal_op), 32'h1);
    tick(); put(6'b000001, 1'b1); settle();
    check_eq("illegal_bubble", 32'(bun), 32'(B_ZERO));
    check_eq("illegal_one_cycle", 32'(illegal_op), 32'h0);
    tick(); check_eq("andi_bundle", 32'(bun), 32'(B_ANDI));
    put(6'b000011, 1'b1); settle();
    check_eq("unmapped_illegal", 32'(illegal_op), 32'h1);
    tick(); put(6'b001010, 1'b1);
    tick(); put(6'b001011, 1'b1); settle();
    check_eq("lbu_bundle", 32'(bun), 32'(B_LBU));
    tick(); put(6'b001101, 1'b1); settle();
    check_eq("sb_bundle", 32'(bun), 32'(B_SB));
    tick(); put(6'b000000, 1'b0); settle();
    check_eq("sw_bundle", 32'(bun), 32'(B_SW));

    // saturation: 298 more overflow events on top of the 2 already counted
    overflow_flag = 1'b1;
    for (int i = 0; i < 252; i++) tick();
    check_eq("errcnt_254", 32'(err_count), 32'd254);
    for (int i = 0; i < 46; i++) tick();
    check_eq("errcnt_sat", 32'(err_count), 32'd255);
    overflow_flag = 1'b0; err_ack = 1'b1;
    tick(); err_ack = 1'b0;

    // reset mid-run, then sticky halt that ignores overflow
    @(negedge clk); reset = 1'b0; #1;
    check_eq("reset_errcnt", 32'(err_count), 32'd0);
    @(negedge clk); reset = 1'b1;
    tick(); put(6'b000000, 1'b1); settle();
    check_eq("halt_flags", 32'(flags), 32'b0_0_0_1_0_0_1_0_0);
    tick(); put(6'b001111, 1'b1);
    tick(); overflow_flag = 1'b1; settle();
    check_eq("halt_ignores_ovf", 32'(flags), 32'b0_0_0_1_0_0_1_0_0);
    check_eq("halt_bubble", 32'(bun), 32'(B_ZERO));
    for (int i = 0; i < 5; i++) tick();
    check_eq("halt_sticky", 32'(flags), 32'b0_0_0_1_0_0_1_0_0);
    check_eq("halt_errcnt0", 32'(err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_seq.md
# pipe_ctrl_seq

Parametrised, registered successor to the combinational pipeline control unit of the 16-bit five-stage CPU. It decodes the ID-stage opcode, registers the EX/MEM/WB control bundle one cycle later, and owns the pipeline's sequencing state: load-use stalls, multi-cycle branch and jump flushes, sticky halt, and an overflow exception that is held until acknowledged. It sits between the IF/ID register and the ID/EX register, and drives the PC and flush logic directly.

## Interface
- OPC_W, 4, opcode width, ≥4; the map occupies bits [3:0]
- REG_AW, 4, register-address width for hazard compare
- FLUSH_CYCLES, 1, cycles IF/ID stay flushed after a taken branch or jmp, 1..7
- ERR_CNT_W, 8, width of the saturating overflow-event counter

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  OPC_W  ID-stage opcode
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_AW  ID source registers
- ex_dst  in  REG_AW  destination register of the instruction now in EX
- branch_result  in  2  comparator result: 01 eq, 10 gt, 11 lt
- overflow_flag  in  1  ALU overflow, EX stage
- err_ack  in  1  exception handler acknowledge
- pc_op, b_jmp, pc_hold  out  1  PC select: redirect, branch vs jump, freeze PC and IF/ID
- if_flush, id_flush, ex_flush  out  1  stage flushes
- halt, overflow_error_warning, illegal_op  out  1  status
- alu_op, mux_a, mux_b, reg_write  out  2 each  registered EX bundle
- mux_c, byte_en, mem_write, r0_select  out  1 each  registered EX bundle
- err_count  out  ERR_CNT_W  saturating count of overflow events

## Operation
- Decode map (alu_op/mux_a/mux_b/mux_c/reg_write/byte_en/mem_write):
  - 1111 A-type: 01/00/00/1/11/0/0
  - 0001 andi: 00/00/11/1/11
  - 0010 ori: 10/00/11/1/11
  - 1010 lbu: 11/11/00/0/11/1/0
  - 1011 sb: 11/11/00/0/00/1/1
  - 1100 lw: 11/11/00/0/11/0/0
  - 1101 sw: 11/11/00/0/00/0/1
  - Branches, jmp and halt: all-zero bundle. Branches never write memory.
- Illegal opcode: any nonzero bit above [3], or an unmapped code. It decodes as a bubble and pulses illegal_op for one cycle when id_valid=1.
- Branches: blt (0101) is taken on branch_result=11, bgt (0100) on 10, beq (0110) on 01.
  - Taken branch: pc_op=1, b_jmp=1, r0_select=1, if_flush=1, id_flush=1.
  - jmp (0111): same as a taken branch, but b_jmp=0 and r0_select=0.
- FSM states: RUN, FLUSH, HALT, EXCEPT. Event priority: overflow > halt opcode > taken branch/jmp > load-use stall.
  - RUN, taken branch/jmp: go to FLUSH if FLUSH_CYCLES>1, otherwise stay in RUN.
  - FLUSH: if_flush=id_flush=1, decode is forced to bubble, pc_op=0. After FLUSH_CYCLES-1 cycles, return to RUN.
  - RUN, halt opcode (0000): halt=if_flush=1 in the same cycle, then go to HALT. HALT is sticky: halt=if_flush=1 and the bundle is bubble until reset.
  - Any state except HALT, overflow_flag=1: ex_flush=id_flush=if_flush=halt=1 and overflow_error_warning=1 in the same cycle; err_count increments, saturating at all-ones; go to EXCEPT.
  - EXCEPT: all flushes, halt and overflow_error_warning held. err_ack=1 returns to RUN next cycle. Overflow and err_ack in the same cycle: stay in EXCEPT and count.
  - HALT: overflow_flag is ignored.
- Load-use stall (RUN only): EX holds lbu or lw, id_valid=1, and ex_dst equals id_src1 or id_src2 → pc_hold=1 and a bubble is loaded into EX. The condition clears after one cycle as the load advances.

## Timing
- Outputs from the current state and opcode, same cycle (combinational): pc_op, b_jmp, pc_hold, if_flush, id_flush, ex_flush, halt, overflow_error_warning, illegal_op.
- EX bundle: registered, 1-cycle latency from opcode. A bubble is loaded on stall, flush, HALT, EXCEPT or an illegal opcode.
- Reset (asserted at any time): every output 0, bundle 0, err_count 0, state RUN, flush counter 0. Release takes effect at the next rising edge.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode localparams
  - state encoding: RUN=0, FLUSH=1, HALT=2, EXCEPT=3
  - branch_result codes
  - EX bundle field widths
- Sub-module ctrl_decode: purely combinational opcode → bundle, plus the illegal flag. It is instantiated once.
- The FSM, flush counter, hazard compare and err_count live in the top module.

## Test plan
- Reset, then lw (1100) followed next cycle by ori (0010) → cycle 2 bundle alu_op=11, mux_a=11, reg_write=11; cycle 3 alu_op=10, mux_b=11.
- lw with ex_dst=3, then ID add with id_src2=3 → pc_hold=1 for exactly 1 cycle, bubble (all zero) in EX, add issues the next cycle.
- FLUSH_CYCLES=3, beq with branch_result=01 → pc_op=b_jmp=r0_select=1 for 1 cycle; if_flush=id_flush=1 for 3 cycles; back in RUN. The same beq with branch_result=10 → no redirect.
- halt opcode, then overflow_flag=1 two cycles later → halt=if_flush=1 permanently, overflow ignored, err_count=0, clears only on reset.
- overflow_flag=1 in RUN → all flushes, halt and overflow_error_warning=1 the same cycle, err_count=1. Overflow together with err_ack → err_count=2, still EXCEPT. err_ack alone → RUN, warning=0.
- OPC_W=6, opcode 010001 with id_valid=1 → illegal_op pulse, bubble bundle; err_count saturates at 255 after 300 overflow events (ERR_CNT_W=8).
